segment_scan_decoder: RTL and testbench
=======================================

Name: segment_scan_decoder

Overview:
- Receive side of the seven-segment display path. Samples the multiplexed segment/digit-select pins driven by the board display driver, decodes each lit pattern back to a 4-bit hex value, and presents per-digit values, error flags and frame strobes.
- Used as an on-chip monitor and as a loopback checker for display drivers in FPGA self-test images.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (one select line per digit), range 1..8
- STABLE_CYCLES, 8, consecutive unchanged synchronized samples required before capture, range 2..255

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  segment lines, active-low (0 = lit); bit0=a(top), bit1=b(rt), bit2=c(rb), bit3=d(bottom), bit4=e(lb), bit5=f(lt), bit6=g(middle)
- dig_sel_n  in  NUM_DIGITS  digit selects, active-low one-hot
- digits_o  out  4*NUM_DIGITS  decoded value per digit; digit i at [4i+3:4i]
- digit_valid_o  out  NUM_DIGITS  digit captured at least once since reset
- digit_err_o  out  NUM_DIGITS  last capture of that digit was not a legal hex pattern
- update_o  out  1  one-cycle pulse: a capture changed a digit's value or error flag
- frame_o  out  1  one-cycle pulse: every digit captured since the last frame_o

Behaviour:
- Reset (async assert, sync release): all outputs, sync flops, counter, FSM and frame mask are 0. FSM enters IDLE.
- Input sync: seg_n and dig_sel_n pass through a 2-flop synchronizer (s1, s2). A third register s3 holds the previous s2.
- Select valid: exactly one bit of s2 dig_sel_n is low. Zero or multiple low bits make the select invalid.
- Stability counter: 8-bit, saturating at STABLE_CYCLES.
  - Clears to 0 when s2 != s3 (any seg or select bit) or the select is invalid.
  - Otherwise increments.
- FSM:
  - IDLE: select invalid. Go to SETTLE when the select becomes valid.
  - SETTLE: counting. When the counter reaches STABLE_CYCLES, perform a capture and go to CAPTURED. Go back to IDLE if the select becomes invalid. Stay in SETTLE with counter 0 if the input changes.
  - CAPTURED: hold. Go to SETTLE when the input changes with a valid select. Go to IDLE when the select becomes invalid. No re-capture while in CAPTURED.
- Capture timing: the capture registers on the edge at which the counter reaches STABLE_CYCLES. Taking edge 1 as the first edge sampling a new, held input into s1, the outputs update on edge STABLE_CYCLES+3.
- Decode table (seg_n[6:0] -> value):
  - 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8
  - 0011000->9, 0001000->A, 0000011->b, 1000110->C
  - 0100001->d, 0000110->E, 0001110->F, 1000000->0
- Capture into digit i (the selected digit):
  - Set digit_valid_o[i].
  - Legal pattern: write the value and clear digit_err_o[i].
  - Any other pattern, including blank 1111111: set digit_err_o[i] and leave the value unchanged.
  - Pulse update_o on the next cycle only if the value or error flag differs from the stored one.
- Frame mask:
  - Set bit i on each capture of digit i.
  - When a capture completes the mask (all ones), frame_o pulses with the same timing as update_o and the mask clears to 0.
  - Re-capturing an already-marked digit has no effect on the mask.
- Boundaries:
  - Select changes on the capture edge: the capture uses the old s2 values. The counter restarts for the new digit.
  - NUM_DIGITS=1: frame_o pulses on every capture.
  - Reset mid-settle: everything clears and no capture occurs.
  - Continuously flickering input never reaches the count and never captures.

Optional Feature:
- Macro: SEGMENT_SCAN_DP_EN
- Defined:
  - Adds input seg_dp_n (1 bit, active-low decimal point) and output digit_dp_o (NUM_DIGITS).
  - seg_dp_n is synchronized and included in the stability compare.
  - digit_dp_o[i] is written on every capture, legal or not, and a change in it also triggers update_o.
- Not defined: neither port exists and decimal points are ignored.

Test Plan:
- STABLE_CYCLES=4; dig_sel_n=1110, seg_n=0100100 held from edge 1 -> digits_o[3:0]=2, digit_valid_o[0]=1, err=0 on edge 7; update_o high for one cycle after.
- Same setup, but seg_n toggles every 3 cycles for 20 cycles -> no capture; digit_valid_o stays 0.
- Digit 1 selected with seg_n=1111111 after a prior capture of 9 -> digits_o[7:4] stays 9, digit_err_o[1]=1, update_o pulses.
- Scan 1110/1101/1011/0111 with patterns 1,A,b,F, 10 cycles each -> digits_o=16'hFbA1; frame_o pulses once after the fourth capture; a second identical scan gives frame_o again with no update_o.
- dig_sel_n=1100 (two digits selected) held for 30 cycles -> FSM stays IDLE, no capture. Then rst_n asserted mid-settle -> all outputs 0 immediately.
- With SEGMENT_SCAN_DP_EN: seg_n=1000000, seg_dp_n=0 on digit 2 -> digits_o[11:8]=0, digit_dp_o[2]=1. Toggling only the dp and re-holding -> update_o pulses.

Source files
------------

// File: rtl/segment_scan_if.sv
// Display pin bundle between a seven-segment driver (master) and the scan
// decoder (slave). With SEGMENT_SCAN_DP_EN defined, the decimal point input
// and the per-digit decimal point outputs are added.
interface segment_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   dig_sel_n;
    logic [4*NUM_DIGITS-1:0] digits_o;
    logic [NUM_DIGITS-1:0]   digit_valid_o;
    logic [NUM_DIGITS-1:0]   digit_err_o;
    logic                    update_o;
    logic                    frame_o;
`ifdef SEGMENT_SCAN_DP_EN
    logic                    seg_dp_n;
    logic [NUM_DIGITS-1:0]   digit_dp_o;

    modport master (
        output seg_n, dig_sel_n, seg_dp_n,
        input  digits_o, digit_valid_o, digit_err_o, update_o, frame_o, digit_dp_o
    );
    modport slave (
        input  seg_n, dig_sel_n, seg_dp_n,
        output digits_o, digit_valid_o, digit_err_o, update_o, frame_o, digit_dp_o
    );
`else
    modport master (
        output seg_n, dig_sel_n,
        input  digits_o, digit_valid_o, digit_err_o, update_o, frame_o
    );
    modport slave (
        input  seg_n, dig_sel_n,
        output digits_o, digit_valid_o, digit_err_o, update_o, frame_o
    );
`endif
endinterface

// File: rtl/segment_scan_decoder.sv
// Seven-segment scan receiver: synchronizes the multiplexed segment/select
// pins, waits for a stable lit pattern on a single selected digit, decodes it
// back to hex and reports per-digit values, error flags and frame strobes.
// Optional decimal point support is enabled with SEGMENT_SCAN_DP_EN.
module segment_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    segment_scan_if.slave   bus
);

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIG_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = 8;
`ifdef SEGMENT_SCAN_DP_EN
    localparam int unsigned IN_W    = SEG_W + NUM_DIGITS + 1;
`else
    localparam int unsigned IN_W    = SEG_W + NUM_DIGITS;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IN_W-1:0]         in_raw;
    logic [IN_W-1:0]         s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIG_W-1:0]        digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    update_q, update_d;
    logic                    frame_q, frame_d;

    logic [SEG_W-1:0]        s2_seg;
    logic [NUM_DIGITS-1:0]   sel_low;
    logic                    s2_dp;
    logic                    sel_valid;
    logic                    in_changed;
    logic                    capture;
    logic [4:0]              dec;
    logic                    any_change;
    logic [NUM_DIGITS-1:0]   mask_new;

    // Returns {legal, value} for an active-low segment pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0011000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

`ifdef SEGMENT_SCAN_DP_EN
    assign in_raw = {bus.seg_dp_n, bus.dig_sel_n, bus.seg_n};
    assign s2_dp  = ~s2_q[IN_W-1];
`else
    assign in_raw = {bus.dig_sel_n, bus.seg_n};
    assign s2_dp  = 1'b0;
`endif

    assign s2_seg     = s2_q[SEG_W-1:0];
    assign sel_low    = ~s2_q[SEG_W +: NUM_DIGITS];
    assign sel_valid  = (sel_low != '0) &&
                        ((sel_low & (sel_low - NUM_DIGITS'(1))) == '0);
    assign in_changed = (s2_q != s3_q);
    assign dec        = decode_seg(s2_seg);

    // Stability counter: restart on any input change or bad select, saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (in_changed || !sel_valid) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign capture = (state_q == ST_SETTLE) && (cnt_d == CNT_MAX);

    // Scan FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!sel_valid)   state_d = ST_IDLE;
                else if (capture) state_d = ST_CAPTURED;
            end
            ST_CAPTURED: begin
                if (!sel_valid)      state_d = ST_IDLE;
                else if (in_changed) state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture into the selected digit and track the frame mask.
    always_comb begin
        digits_d   = digits_q;
        valid_d    = valid_q;
        err_d      = err_q;
        dp_d       = dp_q;
        mask_d     = mask_q;
        mask_new   = mask_q | sel_low;
        any_change = 1'b0;
        frame_d    = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (capture && sel_low[i]) begin
                valid_d[i] = 1'b1;
                if (dec[4]) begin
                    if ((digits_q[4*i +: 4] != dec[3:0]) || err_q[i]) any_change = 1'b1;
                    digits_d[4*i +: 4] = dec[3:0];
                    err_d[i]           = 1'b0;
                end else begin
                    if (!err_q[i]) any_change = 1'b1;
                    err_d[i] = 1'b1;
                end
                if (dp_q[i] != s2_dp) any_change = 1'b1;
                dp_d[i] = s2_dp;
            end
        end
        if (capture) begin
            if (&mask_new) begin
                mask_d  = '0;
                frame_d = 1'b1;
            end else begin
                mask_d = mask_new;
            end
        end
        update_d = any_change;
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            dp_q     <= '0;
            mask_q   <= '0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= in_raw;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            dp_q     <= dp_d;
            mask_q   <= mask_d;
            update_q <= update_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.digits_o      = digits_q;
    assign bus.digit_valid_o = valid_q;
    assign bus.digit_err_o   = err_q;
    assign bus.update_o      = update_q;
    assign bus.frame_o       = frame_q;
`ifdef SEGMENT_SCAN_DP_EN
    assign bus.digit_dp_o    = dp_q;
`endif

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_segment_scan_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   upd_cnt  = 0;
    int   frm_cnt  = 0;
    int   u0, f0;

    segment_scan_if #(.NUM_DIGITS(4)) bus ();

    segment_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count output pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.update_o) upd_cnt = upd_cnt + 1;
        if (bus.frame_o)  frm_cnt = frm_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int cyc);
        bus.dig_sel_n = sel;
        bus.seg_n     = seg;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        bus.seg_n     = 7'b1111111;
        bus.dig_sel_n = 4'b1111;
`ifdef SEGMENT_SCAN_DP_EN
        bus.seg_dp_n  = 1'b1;
`endif
        #1;
        check("rst_digits", 32'(bus.digits_o), 32'h0);
        check("rst_valid",  32'(bus.digit_valid_o), 32'h0);
        check("rst_err",    32'(bus.digit_err_o), 32'h0);
        check("rst_update", 32'(bus.update_o), 32'h0);
        check("rst_frame",  32'(bus.frame_o), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 4);

        // Flickering pattern on digit 0 never settles long enough.
        u0 = upd_cnt;
        bus.dig_sel_n = 4'b1110;
        for (int k = 0; k < 7; k++) begin
            bus.seg_n = (k % 2 == 1) ? 7'b0110000 : 7'b0100100;
            repeat (3) @(negedge clk);
        end
        check("flicker_valid",  32'(bus.digit_valid_o), 32'h0);
        check("flicker_update", 32'(upd_cnt - u0), 32'd0);
        hold(4'b1111, 7'b1111111, 6);

        // Capture of "2" on digit 0 lands exactly on edge 7.
        bus.dig_sel_n = 4'b1110;
        bus.seg_n     = 7'b0100100;
        repeat (6) @(posedge clk);
        #1;
        check("t1_valid_early", 32'(bus.digit_valid_o), 32'h0);
        @(posedge clk);
        #1;
        check("t1_digit0", 32'(bus.digits_o[3:0]), 32'h2);
        check("t1_valid",  32'(bus.digit_valid_o), 32'h1);
        check("t1_err",    32'(bus.digit_err_o), 32'h0);
        check("t1_update", 32'(bus.update_o), 32'h1);
        @(posedge clk);
        #1;
        check("t1_update_off", 32'(bus.update_o), 32'h0);
        @(negedge clk);

        // Digit 1: capture 9, then a blank pattern flags an error.
        hold(4'b1101, 7'b0011000, 10);
        check("t3_digit1", 32'(bus.digits_o[7:4]), 32'h9);
        u0 = upd_cnt;
        hold(4'b1101, 7'b1111111, 10);
        check("t3_digit1_keep", 32'(bus.digits_o[7:4]), 32'h9);
        check("t3_err",         32'(bus.digit_err_o), 32'h2);
        check("t3_valid",       32'(bus.digit_valid_o), 32'h3);
        check("t3_update",      32'(upd_cnt - u0), 32'd1);

        // Clean restart, then two full scans.
        rst_n = 1'b0;
        hold(4'b1111, 7'b1111111, 2);
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 4);
        u0 = upd_cnt;
        f0 = frm_cnt;
        hold(4'b1110, 7'b1111001, 10);
        hold(4'b1101, 7'b0001000, 10);
        hold(4'b1011, 7'b0000011, 10);
        check("scan1_no_early_frame", 32'(frm_cnt - f0), 32'd0);
        hold(4'b0111, 7'b0001110, 10);
        check("scan1_digits", 32'(bus.digits_o), 32'h0000FBA1);
        check("scan1_frame",  32'(frm_cnt - f0), 32'd1);
        check("scan1_update", 32'(upd_cnt - u0), 32'd4);
        u0 = upd_cnt;
        f0 = frm_cnt;
        hold(4'b1110, 7'b1111001, 10);
        hold(4'b1101, 7'b0001000, 10);
        hold(4'b1011, 7'b0000011, 10);
        hold(4'b0111, 7'b0001110, 10);
        check("scan2_frame",  32'(frm_cnt - f0), 32'd1);
        check("scan2_update", 32'(upd_cnt - u0), 32'd0);

        // Two digits selected at once: nothing is captured.
        u0 = upd_cnt;
        f0 = frm_cnt;
        hold(4'b1100, 7'b1111001, 30);
        check("multi_sel_digits", 32'(bus.digits_o), 32'h0000FBA1);
        check("multi_sel_update", 32'(upd_cnt - u0), 32'd0);
        check("multi_sel_frame",  32'(frm_cnt - f0), 32'd0);

`ifdef SEGMENT_SCAN_DP_EN
        // Decimal point on digit 2, then toggle only the dp.
        bus.seg_dp_n = 1'b0;
        hold(4'b1011, 7'b1000000, 10);
        check("dp_digit2", 32'(bus.digits_o[11:8]), 32'h0);
        check("dp_set",    32'(bus.digit_dp_o), 32'h4);
        u0 = upd_cnt;
        bus.seg_dp_n = 1'b1;
        hold(4'b1011, 7'b1000000, 10);
        check("dp_clear",  32'(bus.digit_dp_o), 32'h0);
        check("dp_update", 32'(upd_cnt - u0), 32'd1);
`endif

        // Reset in the middle of settling clears everything at once.
        bus.dig_sel_n = 4'b1110;
        bus.seg_n     = 7'b0000000;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_digits", 32'(bus.digits_o), 32'h0);
        check("midrst_valid",  32'(bus.digit_valid_o), 32'h0);
        check("midrst_update", 32'(bus.update_o), 32'h0);
        hold(4'b1111, 7'b1111111, 3);
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 15);
        check("midrst_no_capture", 32'(bus.digit_valid_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
